conv_window_scheduler: RTL and testbench

//  Sequences one valid-mode KxK convolution pass over an IMG_H x IMG_W frame.

---
 rtl/conv_pkg.sv | 12 +
 rtl/conv_sync_fifo.sv | 51 +++++
 rtl/conv_window_scheduler.sv | 158 +++++++++++++++
 tb/tb_conv_window_scheduler.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared state encoding and default widths for the convolution window scheduler.
package conv_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } conv_state_e;

  localparam int CONV_DATA_WIDTH = 16;
  localparam int CONV_KERNEL     = 3;
endpackage

// File: rtl/conv_sync_fifo.sv
// Small flop-based FIFO with a combinational head; push and pop may coincide at any fill level.
module conv_sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_pop;

  assign empty     = (count_q == '0);
  assign do_pop    = pop && !empty;
  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + CW'(push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/conv_window_scheduler.sv
// Raster-order window request scheduler for one valid-mode KxK convolution pass,
// with fixed-latency return tracking and a credit-protected output FIFO.
module conv_window_scheduler
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = CONV_DATA_WIDTH,
  parameter int KERNEL     = CONV_KERNEL,
  parameter int DIM_WIDTH  = 10,
  parameter int MEM_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIM_WIDTH-1:0]  img_h,
  input  logic [DIM_WIDTH-1:0]  img_w,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic                  win_req_valid,
  input  logic                  win_req_ready,
  output logic [DIM_WIDTH-1:0]  win_row,
  output logic [DIM_WIDTH-1:0]  win_col,
  input  logic [DATA_WIDTH-1:0] tree_sum,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_ISSUE = ISSUE;
  localparam logic [1:0] S_DRAIN = DRAIN;
  localparam logic [1:0] S_DONE  = DONE;
  localparam logic [DIM_WIDTH-1:0] K_DIM = DIM_WIDTH'(KERNEL);

  logic [1:0]           state_q, state_d;
  logic [DIM_WIDTH-1:0] h_q, h_d, w_q, w_d;
  logic [DIM_WIDTH-1:0] row_q, row_d, col_q, col_d;
  logic                 cfg_err_q, cfg_err_d;
  logic [CW-1:0]        inflight_q, inflight_d;
  logic [MEM_LAT-1:0]   sr_valid_q, sr_valid_d, sr_last_q, sr_last_d;

  logic [CW-1:0]        fifo_count;
  logic                 fifo_empty;
  logic [DATA_WIDTH:0]  fifo_head;
  logic                 accept, at_last, ret, pop, dims_ok;
  logic [CW:0]          outstanding;

  // Every accepted window owns a FIFO slot until popped, so a push can never hit a full FIFO.
  assign outstanding   = {1'b0, inflight_q} + {1'b0, fifo_count};
  assign win_req_valid = (state_q == S_ISSUE) && (outstanding < (CW+1)'(FIFO_DEPTH));
  assign accept        = win_req_valid && win_req_ready;
  assign at_last       = (row_q == h_q - K_DIM) && (col_q == w_q - K_DIM);
  assign ret           = sr_valid_q[MEM_LAT-1];
  assign out_valid     = !fifo_empty;
  assign pop           = out_valid && out_ready;
  assign out_data      = out_valid ? fifo_head[DATA_WIDTH-1:0] : '0;
  assign out_last      = out_valid && fifo_head[DATA_WIDTH];
  assign busy          = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done          = (state_q == S_DONE);
  assign cfg_err       = cfg_err_q;
  assign win_row       = row_q;
  assign win_col       = col_q;
  assign dims_ok       = (img_h >= K_DIM) && (img_w >= K_DIM);
  assign sr_valid_d    = (sr_valid_q << 1) | MEM_LAT'(accept);
  assign sr_last_d     = (sr_last_q << 1) | MEM_LAT'(accept && at_last);

  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    w_d       = w_q;
    row_d     = row_q;
    col_d     = col_q;
    cfg_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (dims_ok) begin
            state_d = S_ISSUE;
            h_d     = img_h;
            w_d     = img_w;
            row_d   = '0;
            col_d   = '0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (accept) begin
          if (at_last) begin
            state_d = S_DRAIN;
          end else if (col_q == w_q - K_DIM) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        // The last beat is always the youngest entry, so popping it empties the pipeline.
        if (pop && out_last && (inflight_q == '0) && (fifo_count == CW'(1))) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    inflight_d = inflight_q;
    if (accept && !ret) begin
      inflight_d = inflight_q + 1'b1;
    end else if (!accept && ret) begin
      inflight_d = inflight_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      h_q        <= '0;
      w_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
      cfg_err_q  <= 1'b0;
      inflight_q <= '0;
      sr_valid_q <= '0;
      sr_last_q  <= '0;
    end else begin
      state_q    <= state_d;
      h_q        <= h_d;
      w_q        <= w_d;
      row_q      <= row_d;
      col_q      <= col_d;
      cfg_err_q  <= cfg_err_d;
      inflight_q <= inflight_d;
      sr_valid_q <= sr_valid_d;
      sr_last_q  <= sr_last_d;
    end
  end

  conv_sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (ret),
    .push_data ({sr_last_q[MEM_LAT-1], tree_sum}),
    .pop       (pop),
    .head_data (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );
endmodule

// File: tb/tb_conv_window_scheduler.sv
// Bench for conv_window_scheduler: table-driven frames, a reset-mid-frame sequence and
// randomized frames checked against a queue model of the expected window and beat streams.
module tb_conv_window_scheduler;
  localparam int DW    = 16;
  localparam int K     = 3;
  localparam int DIMW  = 10;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [DIMW-1:0] img_h = '0;
  logic [DIMW-1:0] img_w = '0;
  logic            busy, done, cfg_err, win_req_valid;
  logic            win_req_ready = 1'b0;
  logic [DIMW-1:0] win_row, win_col;
  logic [DW-1:0]   tree_sum = '0;
  logic            out_valid, out_last;
  logic            out_ready = 1'b0;
  logic [DW-1:0]   out_data;

  conv_window_scheduler #(
    .DATA_WIDTH (DW),
    .KERNEL     (K),
    .DIM_WIDTH  (DIMW),
    .MEM_LAT    (LAT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .img_h         (img_h),
    .img_w         (img_w),
    .busy          (busy),
    .done          (done),
    .cfg_err       (cfg_err),
    .win_req_valid (win_req_valid),
    .win_req_ready (win_req_ready),
    .win_row       (win_row),
    .win_col       (win_col),
    .tree_sum      (tree_sum),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last)
  );

  always #5 clk = ~clk;

  typedef struct { int r; int c; } coord_t;
  typedef struct { logic [DW-1:0] d; logic l; int rc; } beat_t;
  typedef struct { int h; int w; int rm; int om; int stall; int exp_reqs; int poke; } vec_t;

  coord_t        req_q[$];
  beat_t         exp_q[$];
  logic [DW-1:0] sched [int];
  int  cyc = 0, acc_cnt = 0, pop_cnt = 0, n_cmp = 0, n_err = 0;
  int  stall_cnt = 0, rmode = 0, omode = 0;
  bit  issuing = 0, in_reset = 1, stall_prev = 0;
  logic [DIMW-1:0] prev_row = '0, prev_col = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Input driver: tree_sum carries the scheduled return only in its return cycle, junk otherwise.
  always @(posedge clk) begin
    #1;
    tree_sum = sched.exists(cyc) ? sched[cyc] : DW'($urandom);
    case (rmode)
      0:       win_req_ready = 1'b1;
      1:       win_req_ready = cyc[0];
      default: win_req_ready = ($urandom_range(0, 3) != 0);
    endcase
    if (stall_cnt > 0) begin
      out_ready = 1'b0;
      stall_cnt--;
    end else if (omode == 0) begin
      out_ready = 1'b1;
    end else begin
      out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // Reference model: expected window list, credit rule, return latency and beat order.
  always @(negedge clk) begin
    int     outstanding;
    bit     exp_ov;
    beat_t  b;
    coord_t c;
    if (!in_reset) begin
      outstanding = acc_cnt - pop_cnt;
      exp_ov = (exp_q.size() > 0) && (exp_q[0].rc <= cyc);
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      if (issuing) chk("req_valid_credit", 32'(win_req_valid), 32'(outstanding < DEPTH));
      else         chk("req_valid_idle", 32'(win_req_valid), 0);
      if (stall_prev) begin
        chk("stall_row_hold", 32'(win_row), 32'(prev_row));
        chk("stall_col_hold", 32'(win_col), 32'(prev_col));
      end
      stall_prev = win_req_valid && !win_req_ready;
      prev_row   = win_row;
      prev_col   = win_col;
      if (win_req_valid && win_req_ready && issuing) begin
        c = req_q.pop_front();
        chk("win_row", 32'(win_row), c.r);
        chk("win_col", 32'(win_col), c.c);
        b.d  = DW'($urandom);
        b.l  = (req_q.size() == 0);
        b.rc = cyc + LAT + 1;
        sched[cyc + LAT] = b.d;
        exp_q.push_back(b);
        acc_cnt++;
        if (req_q.size() == 0) issuing = 0;
      end
      if (out_valid && out_ready) begin
        chk("beat_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          b = exp_q.pop_front();
          chk("out_data", 32'(out_data), 32'(b.d));
          chk("out_last", 32'(out_last), 32'(b.l));
        end
        pop_cnt++;
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_busy"},      32'(busy), 0);
    chk({tag, "_done"},      32'(done), 0);
    chk({tag, "_cfg_err"},   32'(cfg_err), 0);
    chk({tag, "_req_valid"}, 32'(win_req_valid), 0);
    chk({tag, "_win_row"},   32'(win_row), 0);
    chk({tag, "_win_col"},   32'(win_col), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_out_data"},  32'(out_data), 0);
    chk({tag, "_out_last"},  32'(out_last), 0);
  endtask

  task automatic load_model(input int h, input int w);
    req_q.delete();
    exp_q.delete();
    acc_cnt = 0;
    pop_cnt = 0;
    if (h >= K && w >= K)
      for (int r = 0; r <= h - K; r++)
        for (int c = 0; c <= w - K; c++) req_q.push_back('{r, c});
  endtask

  task automatic run_frame(input vec_t v);
    bit ok;
    int n;
    ok = (v.h >= K) && (v.w >= K);
    rmode = v.rm;
    omode = v.om;
    @(posedge clk); #1;
    load_model(v.h, v.w);
    img_h = DIMW'(v.h);
    img_w = DIMW'(v.w);
    start = 1'b1;
    stall_cnt = v.stall;
    @(posedge clk); #1;
    start = 1'b0;
    img_h = DIMW'($urandom);
    img_w = DIMW'($urandom);
    issuing = ok;
    @(negedge clk);
    chk("cfg_err_pulse", 32'(cfg_err), 32'(!ok));
    chk("busy_after_start", 32'(busy), 32'(ok));
    if (v.poke != 0) begin
      @(posedge clk); #1;
      start = 1'b1;
      img_h = DIMW'(1);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("start_busy_ignored", 32'(cfg_err), 0);
    end
    n = 0;
    if (ok) begin
      while (!done && n < 3000) begin
        @(negedge clk);
        n++;
      end
      chk("done_seen", 32'(done), 1);
      chk("exp_q_empty", 32'(exp_q.size()), 0);
    end else begin
      repeat (4) @(negedge clk);
    end
    chk("req_count", 32'(acc_cnt), 32'(v.exp_reqs));
    chk("beat_count", 32'(pop_cnt), 32'(v.exp_reqs));
    @(negedge clk);
    chk("done_pulse_end", 32'(done), 0);
    chk("busy_end", 32'(busy), 0);
    chk("cfg_err_end", 32'(cfg_err), 0);
  endtask

  task automatic reset_mid_frame();
    rmode = 0;
    omode = 0;
    @(posedge clk); #1;
    load_model(6, 6);
    img_h = DIMW'(6);
    img_w = DIMW'(6);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    issuing = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("pre_reset_accepts", 32'(acc_cnt), 3);
    rst = 1'b1;
    in_reset = 1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("mid_reset");
    @(posedge clk); #1;
    load_model(0, 0);
    issuing = 0;
    stall_prev = 0;
    in_reset = 0;
  endtask

  initial begin
    vec_t tbl[8];
    vec_t v;
    tbl[0] = '{3, 3, 0, 0, 0,  1,  0};
    tbl[1] = '{4, 5, 0, 0, 0,  6,  0};
    tbl[2] = '{6, 6, 0, 0, 20, 16, 0};
    tbl[3] = '{5, 6, 1, 0, 0,  12, 0};
    tbl[4] = '{2, 5, 0, 0, 0,  0,  0};
    tbl[5] = '{5, 2, 0, 0, 0,  0,  0};
    tbl[6] = '{7, 9, 2, 1, 0,  35, 1};
    tbl[7] = '{3, 10, 2, 1, 0, 8,  0};

    rst = 1'b1;
    in_reset = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    in_reset = 0;

    for (int i = 0; i < 8; i++) begin
      run_frame(tbl[i]);
      $display("frame %0d: %0dx%0d reqs=%0d beats=%0d", i, tbl[i].h, tbl[i].w, acc_cnt, pop_cnt);
    end

    reset_mid_frame();
    v = '{5, 5, 2, 1, 0, 9, 0};
    run_frame(v);
    $display("post-reset frame: 5x5 reqs=%0d beats=%0d", acc_cnt, pop_cnt);

    for (int i = 0; i < 6; i++) begin
      v.h = $urandom_range(3, 8);
      v.w = $urandom_range(3, 9);
      v.rm = 2;
      v.om = 1;
      v.stall = $urandom_range(0, 1) * 8;
      v.exp_reqs = (v.h - K + 1) * (v.w - K + 1);
      v.poke = 0;
      run_frame(v);
      $display("random frame %0d: %0dx%0d reqs=%0d beats=%0d", i, v.h, v.w, acc_cnt, pop_cnt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
